mem_io_controller: RTL

//  Sequences every load/store the datapath issues. Decodes the address to data memory or memory-mapped I/O (KEY, SW, HEX, LEDR, LEDG).

---
 rtl/mem_io_controller_pkg.sv | 29 ++
 rtl/mem_io_controller_if.sv | 24 ++
 rtl/mem_io_controller_key_debouncer.sv | 36 +++
 rtl/mem_io_controller.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/mem_io_controller_pkg.sv
// Shared address map, DMEM geometry and FSM encoding for the load/store controller.
package mmio_pkg;

    localparam int DBITS        = 32;
    localparam int DMEMADDRBITS = 13;
    localparam int DMEMWORDBITS = 2;
    localparam int DMEMWORDS    = 2048;
    localparam int DMEM_AW      = DMEMADDRBITS - DMEMWORDBITS;

    localparam logic [DBITS-1:0] ADDR_HEX  = 32'hF000_0000;
    localparam logic [DBITS-1:0] ADDR_LEDR = 32'hF000_0004;
    localparam logic [DBITS-1:0] ADDR_LEDG = 32'hF000_0008;
    localparam logic [DBITS-1:0] ADDR_KEY  = 32'hF000_0010;
    localparam logic [DBITS-1:0] ADDR_SW   = 32'hF000_0014;

    localparam logic [15:0] DEBOUNCE_CYCLES_DEF = 16'd50000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    function automatic logic is_dmem(input logic [DBITS-1:0] addr);
        return addr[DBITS-1:DMEMADDRBITS] == '0;
    endfunction

endpackage

// File: rtl/mem_io_controller_if.sv
// Request/response bus between the datapath (master) and the controller (slave).
interface mem_io_controller_if;
    import mmio_pkg::*;

    logic             req_valid;
    logic             req_we;
    logic [DBITS-1:0] req_addr;
    logic [DBITS-1:0] req_wdata;
    logic             req_ready;
    logic             rsp_valid;
    logic [DBITS-1:0] rsp_rdata;
    logic             rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/mem_io_controller_key_debouncer.sv
// Per-bit debouncer: a bit's output follows its input only after CNT consecutive
// samples that differ from the current output.
module key_debouncer #(
    parameter int          W   = 4,
    parameter logic [15:0] CNT = 16'd50000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] i_in,
    output logic [W-1:0] o_out
);

    logic [W-1:0][15:0] r_cnt;
    logic [W-1:0]       r_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_out <= '0;
        end else begin
            for (int i = 0; i < W; i++) begin
                if (i_in[i] == r_out[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT - 16'd1) begin
                    r_out[i] <= i_in[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 16'd1;
                end
            end
        end
    end

    assign o_out = r_out;

endmodule

// File: rtl/mem_io_controller.sv
// Load/store sequencer for DMEM and the KEY/SW/HEX/LEDR/LEDG registers.
// Optional KEY debouncing is enabled with MMIO_KEY_DEBOUNCE_EN.
module mem_io_controller
    import mmio_pkg::*;
`ifdef MMIO_KEY_DEBOUNCE_EN
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
)
`endif
(
    input  logic               clk,
    input  logic               reset,
    mem_io_controller_if.slave bus,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic               dmem_we,
    output logic [DBITS-1:0]   dmem_wdata,
    input  logic [DBITS-1:0]   dmem_rdata,
    input  logic [3:0]         key_in,
    input  logic [9:0]         sw_in,
    output logic [15:0]        hex_out,
    output logic [9:0]         ledr_out,
    output logic [7:0]         ledg_out
);

    state_t             r_state, w_next;
    logic               r_we;
    logic [DBITS-1:0]   r_addr, r_wdata, r_rdata;
    logic               r_err;
    logic [3:0]         r_key_s1, r_key_s2;
    logic [9:0]         r_sw_s1, r_sw_s2;
    logic [15:0]        r_hex;
    logic [9:0]         r_ledr;
    logic [7:0]         r_ledg;
    logic               r_rsp_valid, r_rsp_err;
    logic [DBITS-1:0]   r_rsp_rdata;

    logic               w_dmem, w_hex, w_ledr, w_ledg, w_key, w_sw, w_io, w_err, w_dmem_ok;
    logic [3:0]         w_key_pressed, w_key_val;
    logic [DBITS-1:0]   w_io_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_key_s1 <= '0;
            r_key_s2 <= '0;
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
        end else begin
            r_key_s1 <= key_in;
            r_key_s2 <= r_key_s1;
            r_sw_s1  <= sw_in;
            r_sw_s2  <= r_sw_s1;
        end
    end

    // Board keys are active-low; everything downstream sees 1 = pressed.
    assign w_key_pressed = ~r_key_s2;

`ifdef MMIO_KEY_DEBOUNCE_EN
    key_debouncer #(.W(4), .CNT(DEBOUNCE_CYCLES)) u_key_debouncer (
        .clk   (clk),
        .reset (reset),
        .i_in  (w_key_pressed),
        .o_out (w_key_val)
    );
`else
    assign w_key_val = w_key_pressed;
`endif

    assign w_dmem    = is_dmem(r_addr);
    assign w_hex     = (r_addr == ADDR_HEX);
    assign w_ledr    = (r_addr == ADDR_LEDR);
    assign w_ledg    = (r_addr == ADDR_LEDG);
    assign w_key     = (r_addr == ADDR_KEY);
    assign w_sw      = (r_addr == ADDR_SW);
    assign w_io      = w_hex | w_ledr | w_ledg | w_key | w_sw;
    assign w_err     = (r_addr[1:0] != 2'b00) | (~w_dmem & ~w_io) | (r_we & (w_key | w_sw));
    assign w_dmem_ok = w_dmem & ~w_err;

    always_comb begin
        w_io_rdata = '0;
        if (w_hex)  w_io_rdata[15:0] = r_hex;
        if (w_ledr) w_io_rdata[9:0]  = r_ledr;
        if (w_ledg) w_io_rdata[7:0]  = r_ledg;
        if (w_key)  w_io_rdata[3:0]  = w_key_val;
        if (w_sw)   w_io_rdata[9:0]  = r_sw_s2;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.req_valid) w_next = ACCESS;
            ACCESS:  w_next = (w_dmem_ok && !r_we) ? WAIT : RESP;
            WAIT:    w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_hex       <= '0;
            r_ledr      <= '0;
            r_ledg      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: if (bus.req_valid) begin
                    r_we    <= bus.req_we;
                    r_addr  <= bus.req_addr;
                    r_wdata <= bus.req_wdata;
                end
                ACCESS: begin
                    r_err   <= w_err;
                    r_rdata <= (!w_err && !r_we) ? w_io_rdata : '0;
                    if (!w_err && r_we) begin
                        if (w_hex)  r_hex  <= r_wdata[15:0];
                        if (w_ledr) r_ledr <= r_wdata[9:0];
                        if (w_ledg) r_ledg <= r_wdata[7:0];
                    end
                end
                WAIT: r_rdata <= dmem_rdata;
                RESP: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_rdata <= r_rdata;
                    r_rsp_err   <= r_err;
                end
                default: ;
            endcase
        end
    end

    // Strobe is decoded from the state so an async reset drops it at once.
    assign dmem_we    = (r_state == ACCESS) & r_we & w_dmem_ok;
    assign dmem_addr  = r_addr[DMEMADDRBITS-1:DMEMWORDBITS];
    assign dmem_wdata = r_wdata;

    assign bus.req_ready = (r_state == IDLE);
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;

    assign hex_out  = r_hex;
    assign ledr_out = r_ledr;
    assign ledg_out = r_ledg;

endmodule
